if_id_fifo: RTL

Parametrised IF→ID decoupling buffer that replaces the single-entry IF/ID pipeline register. It holds up to DEPTH fetched {pc, inst} pairs, accepts pushes from the fetch stage under a valid/ready handshake and presents the oldest entry to decode. Decode can stall the head while fetch keeps running until the buffer fills. A branch/jump flush empties the whole buffer in one cycle. When the buffer is empty it presents a zero bubble (pc = inst = 0) to decode, exactly as the old register did.

---
 rtl/if_id_fifo_pkg.sv | 13 +
 rtl/ifq_ram.sv | 28 ++
 rtl/if_id_fifo.sv | 95 +++++++++
 3 files changed

// File: rtl/if_id_fifo_pkg.sv
// rtl/if_id_fifo_pkg.sv - shared widths and depth defaults for the IF->ID buffer
package if_id_fifo_pkg;

    localparam int ADDR_LEN  = 32;
    localparam int INST_LEN  = 32;
    localparam int IFQ_DEPTH = 4;

    typedef struct packed {
        logic [ADDR_LEN-1:0] pc;
        logic [INST_LEN-1:0] inst;
    } ifq_entry_t;

endpackage

// File: rtl/ifq_ram.sv
// rtl/ifq_ram.sv - DEPTH x WIDTH register array, one sync write port, one async read port
import if_id_fifo_pkg::*;

module ifq_ram #(
    parameter int DEPTH = IFQ_DEPTH,
    parameter int WIDTH = ADDR_LEN + INST_LEN,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    // Storage is deliberately not reset; validity is tracked by the pointers and count.
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_fifo.sv
// rtl/if_id_fifo.sv - IF->ID decoupling FIFO with flush and zero bubble; optional IFQ_BYPASS_EN
import if_id_fifo_pkg::*;

module if_id_fifo #(
    parameter int ADDR_W = ADDR_LEN,
    parameter int INST_W = INST_LEN,
    parameter int DEPTH  = IFQ_DEPTH,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic [INST_W-1:0] if_inst,
    input  logic              ifid_clear,
    input  logic              id_stall,
    output logic              id_valid,
    output logic [ADDR_W-1:0] id_pc,
    output logic [INST_W-1:0] id_inst,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = ADDR_W + INST_W;

    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [ENTRY_W-1:0] rd_entry;
    logic               head_valid;
    logic               push;
    logic               pop;
    logic               wr_en;

    // if_ready looks only at registered count, so a same-cycle pop never frees a slot.
    assign if_ready   = (count < CNT_W'(DEPTH));
    assign head_valid = (count != '0);
    assign pop        = head_valid && !id_stall;

`ifdef IFQ_BYPASS_EN
    logic bypass;

    assign bypass   = !head_valid && !ifid_clear && if_valid;
    assign id_valid = head_valid || bypass;
    assign id_pc    = head_valid ? rd_entry[ENTRY_W-1:INST_W] : (bypass ? if_pc : '0);
    assign id_inst  = head_valid ? rd_entry[INST_W-1:0] : (bypass ? if_inst : '0);
    // A bypassed entry consumed by decode this cycle never enters storage.
    assign push     = if_valid && if_ready && !(bypass && !id_stall);
`else
    assign id_valid = head_valid;
    assign id_pc    = head_valid ? rd_entry[ENTRY_W-1:INST_W] : '0;
    assign id_inst  = head_valid ? rd_entry[INST_W-1:0] : '0;
    assign push     = if_valid && if_ready;
`endif

    assign wr_en = push && !ifid_clear;

    ifq_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W),
        .PTR_W (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata ({if_pc, if_inst}),
        .raddr (rd_ptr),
        .rdata (rd_entry)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (ifid_clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
